// File: rtl/ntt_arith_pkg.sv
// Shared types and helpers for the NTT arithmetic datapath.
// Holds the divider state encoding and a signed-magnitude helper.
package ntt_arith_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 13;
  localparam int unsigned ABS_W          = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Magnitude of a sign-extended operand; callers truncate to their own width.
  function automatic logic [ABS_W-1:0] abs_w(input logic signed [ABS_W-1:0] x);
    logic [ABS_W-1:0] mag;
    if (x[ABS_W-1]) mag = $unsigned(-x);
    else            mag = $unsigned(x);
    return mag;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, and emit one quotient bit.
module seq_div_step #(
  parameter int unsigned W = 13
) (
  input  logic [W:0]   prem,
  input  logic         dvd_msb,
  input  logic [W-1:0] dsr,
  output logic [W:0]   prem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+2:0] trial;

  // One guard bit above the shifted remainder turns the borrow into a sign.
  always_comb begin
    shifted   = {prem, dvd_msb};
    trial     = {1'b0, shifted} - (W+3)'(dsr);
    q_bit     = ~trial[W+2];
    prem_next = q_bit ? (W+1)'(trial) : (W+1)'(shifted);
  end

endmodule

// File: rtl/seq_div_r2.sv
// Sequential signed divider, 2W-bit dividend by W-bit divisor, one quotient
// bit per cycle on magnitudes, sign fix-up at the end, valid/ready on both sides.
module seq_div_r2
  import ntt_arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [2*DATA_WIDTH-1:0]   dividend_i,
  input  logic [DATA_WIDTH-1:0]     divisor_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [2*DATA_WIDTH-1:0]   quot_o,
  output logic [DATA_WIDTH-1:0]     rem_o,
  output logic                      div_zero_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned DW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    dvd;      // dividend magnitude, becomes quotient magnitude
  logic [W-1:0]     dsr;
  logic [W:0]       prem;
  logic             sign_q;
  logic             sign_r;

  logic [DW-1:0]    dvd_mag;
  logic [W-1:0]     dsr_mag;
  logic [W:0]       prem_next;
  logic             q_bit;

  assign in_ready_o = (state == IDLE);
  assign dvd_mag    = DW'(abs_w(ABS_W'($signed(dividend_i))));
  assign dsr_mag    = W'(abs_w(ABS_W'($signed(divisor_i))));

  seq_div_step #(
    .W (W)
  ) u_step (
    .prem      (prem),
    .dvd_msb   (dvd[DW-1]),
    .dsr       (dsr),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      out_valid_o <= 1'b0;
      quot_o      <= '0;
      rem_o       <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            dvd    <= dvd_mag;
            dsr    <= dsr_mag;
            sign_q <= dividend_i[DW-1] ^ divisor_i[W-1];
            sign_r <= dividend_i[DW-1];
            prem   <= '0;
            cnt    <= CNT_LAST;
            if (divisor_i == '0) begin
              // Divide by zero skips the iteration and reports right away.
              quot_o      <= '1;
              rem_o       <= dividend_i[W-1:0];
              div_zero_o  <= 1'b1;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd  <= {dvd[DW-2:0], q_bit};
          prem <= prem_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quot_o      <= sign_q ? DW'(-dvd) : dvd;
          rem_o       <= sign_r ? W'(-prem) : W'(prem);
          div_zero_o  <= 1'b0;
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_r2.sv
// Bench for seq_div_r2: directed corner cases plus randomized signed operands
// checked against integer division/modulo on wide signed values.
module tb_seq_div_r2;

  localparam int W  = 13;
  localparam int DW = 26;
  localparam int LAT_NORM = 2 * W + 2;
  localparam int LAT_DZ   = 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] dividend_i;
  logic [W-1:0]  divisor_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] quot_o;
  logic [W-1:0]  rem_o;
  logic          div_zero_o;

  int total = 0;
  int bad   = 0;

  seq_div_r2 #(.DATA_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quot_o      (quot_o),
    .rem_o       (rem_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: truncating signed division on wide integers.
  function automatic void model(input longint a, input longint b,
                                output logic [DW-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    if (b == 0) begin
      q = '1; r = W'(a); dz = 1'b1; lat = LAT_DZ;
    end else begin
      q = DW'(a / b); r = W'(a % b); dz = 1'b0; lat = LAT_NORM;
    end
  endfunction

  function automatic longint rand_dividend();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return longint'(t);
  endfunction

  function automatic longint rand_divisor();
    logic signed [W-1:0] t;
    case ($urandom_range(0, 7))
      0:       t = '0;
      1:       t = W'($urandom_range(1, 4));
      2:       t = -W'($urandom_range(1, 4));
      3:       t = 13'sh1000;
      default: t = W'($urandom);
    endcase
    return longint'(t);
  endfunction

  // Present one operand pair, then count edges (accept edge = 1) until out_valid.
  task automatic issue(input longint a, input longint b, output int lat);
    int guard = 0;
    while (!in_ready_o && guard < 100) begin
      @(posedge clk_i); #1; guard++;
    end
    in_valid_i = 1'b1;
    dividend_i = DW'(a);
    divisor_i  = W'(b);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    dividend_i = DW'($urandom);
    divisor_i  = W'($urandom);
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      @(posedge clk_i); #1; lat++;
    end
  endtask

  task automatic accept();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (out_valid_o !== 1'b0 || quot_o !== '0 || rem_o !== '0 || div_zero_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b q=%h r=%h dz=%b want 0/0/0/0",
               out_valid_o, quot_o, rem_o, div_zero_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", in_ready_o);
    end
  endtask

  task automatic test_directed();
    longint a_tab[8] = '{11082241, -1000, 1000, -1000, -33554432, 33554431, 0, 5};
    longint b_tab[8] = '{3329, 7, -7, -7, -1, -4096, 5, -4096};
    logic [DW-1:0] eq; logic [W-1:0] er; logic edz; int elat, lat;
    for (int i = 0; i < 8; i++) begin
      model(a_tab[i], b_tab[i], eq, er, edz, elat);
      issue(a_tab[i], b_tab[i], lat);
      total++;
      if (lat != elat) begin
        bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, elat);
      end
      total++;
      if (quot_o !== eq || rem_o !== er || div_zero_o !== edz) begin
        bad++;
        $display("FAIL dir_result[%0d] %0d/%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, a_tab[i], b_tab[i], quot_o, rem_o, div_zero_o, eq, er, edz);
      end
      accept();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(12345, 0, lat);
    total++;
    if (lat != LAT_DZ) begin
      bad++; $display("FAIL dz_latency: got %0d want %0d", lat, LAT_DZ);
    end
    total++;
    if (quot_o !== 26'h3FFFFFF || rem_o !== 13'h1039 || div_zero_o !== 1'b1) begin
      bad++;
      $display("FAIL dz_result: got q=%h r=%h dz=%b want q=3ffffff r=1039 dz=1",
               quot_o, rem_o, div_zero_o);
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] eq; logic [W-1:0] er; logic edz; int elat, lat;
    model(-777777, 123, eq, er, edz, elat);
    issue(-777777, 123, lat);
    total++;
    if (lat != elat) begin
      bad++; $display("FAIL bp_latency: got %0d want %0d", lat, elat);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid_i = 1'b1; dividend_i = 26'd999; divisor_i = 13'd3;
      @(posedge clk_i); #1;
      total++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || quot_o !== eq || rem_o !== er) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=%h r=%h",
                 c, out_valid_o, in_ready_o, quot_o, rem_o, eq, er);
      end
    end
    in_valid_i = 1'b0;
    accept();
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [DW-1:0] eq; logic [W-1:0] er; logic edz; int elat, lat;
    in_valid_i = 1'b1; dividend_i = 26'd5000000; divisor_i = 13'd17;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || quot_o !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: got v=%b q=%h want v=0 q=0", out_valid_o, quot_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ready: got %b want 1", in_ready_o);
    end
    model(3329 * 1234, 1234, eq, er, edz, elat);
    issue(3329 * 1234, 1234, lat);
    total++;
    if (lat != elat || quot_o !== eq || rem_o !== er || div_zero_o !== edz) begin
      bad++;
      $display("FAIL rst_mid_next: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
               lat, quot_o, rem_o, div_zero_o, elat, eq, er, edz);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] eq; logic [W-1:0] er; logic edz; int elat, lat;
    longint a, b;
    for (int i = 0; i < 6; i++) begin
      a = rand_dividend(); b = rand_divisor();
      model(a, b, eq, er, edz, elat);
      issue(a, b, lat);
      total++;
      if (lat != elat || quot_o !== eq || rem_o !== er || div_zero_o !== edz) begin
        bad++;
        $display("FAIL b2b[%0d] %0d/%0d: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
                 i, a, b, lat, quot_o, rem_o, div_zero_o, elat, eq, er, edz);
      end
      accept();
      total++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL b2b_ready[%0d]: got rdy=%b v=%b want rdy=1 v=0", i, in_ready_o, out_valid_o);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] eq; logic [W-1:0] er; logic edz; int elat, lat;
    longint a, b;
    for (int i = 0; i < 40; i++) begin
      a = rand_dividend(); b = rand_divisor();
      model(a, b, eq, er, edz, elat);
      issue(a, b, lat);
      total++;
      if (lat != elat || quot_o !== eq || rem_o !== er || div_zero_o !== edz) begin
        bad++;
        $display("FAIL rand[%0d] %0d/%0d: got lat=%0d q=%h r=%h dz=%b want lat=%0d q=%h r=%h dz=%b",
                 i, a, b, lat, quot_o, rem_o, div_zero_o, elat, eq, er, edz);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
